dff_bist: RTL
=============

# dff_bist

Synthesizable built-in self-test driver for a D flip-flop with asynchronous active-low preset and clear (ports D, PRE, CLR, CLK, Q, Qn). On a START request it runs a fixed 8-step vector sequence against the flop under test, checks Q and Qn after every step, and reports pass/fail with the first failing step. It runs the bench stimulus on-chip and sits beside the flip-flop block it exercises.

## Interface
- SETTLE_CYC, 2: settle cycles after applying inputs and after the DUT clock falls; legal range 1..15.

- CLK  in  1  system clock, rising edge
- CLR  in  1  asynchronous active-low reset of this block
- START  in  1  run request, sampled in IDLE only
- D_O  out  1  to DUT D
- PRE_O  out  1  to DUT PRE, active-low
- CLR_O  out  1  to DUT CLR, active-low
- CLK_O  out  1  to DUT CLK, registered
- Q_I  in  1  from DUT Q
- Qn_I  in  1  from DUT Qn
- BUSY  out  1  sequence running
- DONE  out  1  sequence finished, level
- PASS  out  1  valid when DONE=1
- FAIL_STEP  out  3  first failing step index, valid when DONE=1 and PASS=0

One clock; reset is asynchronous and active-low.

## Operation
- Reset (CLR=0), immediate: PRE_O=1, CLR_O=1, D_O=0, CLK_O=0, BUSY=0, DONE=0, PASS=0, FAIL_STEP=0, state IDLE, step=0.
- Vector ROM, as step: PRE,CLR,D,clocked -> expected Q:
  - 0: 0,1,0,no -> 1
  - 1: 1,0,1,no -> 0
  - 2: 1,1,1,yes -> 1
  - 3: 1,1,0,yes -> 0
  - 4: 1,1,1,no -> 0 (hold)
  - 5: 1,1,1,yes -> 1
  - 6: 1,0,1,yes -> 0 (clear dominates clock)
  - 7: 1,1,0,no -> 0 (hold)
- PRE=0 with CLR=0 is never driven.
- States: IDLE, APPLY, SETTLE, CLK_HI, CLK_LO, CHECK, FIN.
  - IDLE: START=1 -> APPLY, step=0, BUSY=1, DONE=0, PASS=0, FAIL_STEP=0.
  - APPLY (1 cycle): PRE_O, CLR_O, D_O are registered from ROM[step] on the entering edge -> SETTLE.
  - SETTLE (SETTLE_CYC cycles): clocked step -> CLK_HI, otherwise -> CHECK.
  - CLK_HI (1 cycle): CLK_O=1 -> CLK_LO.
  - CLK_LO (SETTLE_CYC cycles): CLK_O=0 -> CHECK.
  - CHECK (1 cycle): Q_I/Qn_I are compared on the leaving edge. Step is good iff Q_I == expQ and Qn_I == ~expQ. step 7 or stop condition -> FIN, otherwise step+1 -> APPLY.
  - FIN: BUSY=0, DONE=1, PASS=no failure recorded -> IDLE.
- On the first failure, FAIL_STEP latches step. Later failures do not overwrite it.
- DUT inputs hold their last values between steps and after completion.
- START while BUSY=1 is ignored. DONE, PASS and FAIL_STEP hold until the next accepted START.
- Q_I/Qn_I are treated as synchronous to CLK (DUT clocked by CLK_O; settle cycles cover propagation). No synchronizer.

## Timing
- Step length: unclocked 2+SETTLE_CYC; clocked 3+2·SETTLE_CYC.
- SETTLE_CYC=2: unclocked 4, clocked 7; full run 4·4+4·7 = 44 cycles.
- DONE rises on edge START_edge+45 (APPLY of step 0 starts at START_edge+1; FIN at +45).
- CLK_O is high for exactly one CLK period per clocked step. D_O/PRE_O/CLR_O are stable ≥ 1+SETTLE_CYC cycles before the CLK_O rise and through the CLK_O fall.
- Reset mid-run: all outputs return to reset values asynchronously. CLK_O drops within the reset, with no partial pulse afterwards.

## Configuration
- DFF_BIST_STOP_EN defined: the first failing CHECK goes directly to FIN. DONE comes early, PASS=0, FAIL_STEP = that step.
- DFF_BIST_STOP_EN undefined: all 8 steps always run. DONE at +45 regardless; FAIL_STEP = first failing step.

## Test plan
- Correct DFF model, SETTLE_CYC=2, START one-cycle pulse -> BUSY=1 for 44 cycles, DONE=1 at +45, PASS=1, FAIL_STEP=0, CLK_O exactly 4 pulses.
- DFF with Q stuck at 0 -> PASS=0, FAIL_STEP=0. With DFF_BIST_STOP_EN, DONE at +5; without, DONE at +45.
- DFF ignoring async CLR while clocked (Q follows D) -> step 6 fails: FAIL_STEP=6, PASS=0.
- DUT with Qn tied to Q (Q correct) -> FAIL_STEP=0, PASS=0.
- CLR asserted during step 3 CLK_HI -> immediately CLK_O=0, PRE_O=1, CLR_O=1, BUSY=0, DONE=0. After release, START -> full passing run, DONE at +45.
- START pulses at +10 and +30 during a run -> ignored, run completes at +45. START held high continuously -> new run begins the cycle after FIN and DONE clears.

Source files
------------

// File: rtl/dff_bist.sv
// -----------------------------------------------------------------------------
// dff_bist
//
// Built-in self-test driver for a D flip-flop with asynchronous active-low
// preset and clear. A START request runs a fixed 8-step vector sequence
// against the flop under test. Q/Qn are checked after every step, and the
// block reports pass/fail together with the index of the first failing step.
//
// Build option:
//   DFF_BIST_STOP_EN  - when defined, the first failing CHECK ends the run at
//                       once (early DONE). When undefined, all 8 steps run.
//
// Parameters:
//   SETTLE_CYC  - settle cycles after applying inputs and after the DUT clock
//                 falls. Legal range is 1..15.
//
// Ports:
//   CLK        in   system clock, rising edge
//   CLR        in   asynchronous active-low reset of this block
//   START      in   run request, sampled in IDLE only
//   D_O        out  to DUT D
//   PRE_O      out  to DUT PRE (active-low)
//   CLR_O      out  to DUT CLR (active-low)
//   CLK_O      out  to DUT CLK (registered, one CLK period high per clocked step)
//   Q_I        in   from DUT Q
//   Qn_I       in   from DUT Qn
//   BUSY       out  sequence running
//   DONE       out  sequence finished (level)
//   PASS       out  result, valid while DONE=1
//   FAIL_STEP  out  first failing step, valid while DONE=1 and PASS=0
//   dbg_state  out  current FSM state encoding
//
// Handshake: START is a request level that the block samples only in IDLE.
// Sampling START=1 in IDLE accepts the run: BUSY rises and DONE/PASS/FAIL_STEP
// clear on the same edge. START is ignored while BUSY=1. When the run ends,
// BUSY falls and DONE rises on the same edge. DONE, PASS and FAIL_STEP then
// hold until the next accepted START.
//
// Q_I/Qn_I are treated as synchronous to CLK. The DUT is clocked from CLK_O,
// and the settle cycles cover propagation, so there is no synchronizer.
// -----------------------------------------------------------------------------
module dff_bist #(
    parameter int SETTLE_CYC = 2
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       START,
    output logic       D_O,
    output logic       PRE_O,
    output logic       CLR_O,
    output logic       CLK_O,
    input  logic       Q_I,
    input  logic       Qn_I,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [2:0] FAIL_STEP,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_APPLY  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_CLK_HI = 3'd3;
    localparam logic [2:0] S_CLK_LO = 3'd4;
    localparam logic [2:0] S_CHECK  = 3'd5;
    localparam logic [2:0] S_FIN    = 3'd6;

    // A settle phase of N cycles loads N-1 and leaves when the count reaches 0.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    // Bit i gives the expected Q after step i.
    localparam logic [7:0] EXP_Q   = 8'b0010_0101;
    // Bit i is set when step i pulses the DUT clock.
    localparam logic [7:0] CLOCKED = 8'b0110_1100;

    // Vector ROM: {PRE, CLR, D} for each step. PRE and CLR are never both low.
    function automatic logic [2:0] rom_pins(input logic [2:0] s);
        logic [2:0] v;
        case (s)
            3'd0:    v = 3'b010;  // preset
            3'd1:    v = 3'b101;  // clear
            3'd2:    v = 3'b111;  // clock in 1
            3'd3:    v = 3'b110;  // clock in 0
            3'd4:    v = 3'b111;  // D=1 without clock: hold 0
            3'd5:    v = 3'b111;  // clock in 1
            3'd6:    v = 3'b101;  // clear held while clocking D=1
            default: v = 3'b110;  // D=0 without clock: hold 0
        endcase
        return v;
    endfunction

    logic [2:0] state;
    logic [2:0] step;
    logic [3:0] cnt;
    logic       fail_seen;

    logic [2:0] step_inc;
    logic       exp_bit;
    logic       step_good;
    logic       end_run;

    assign step_inc  = step + 3'd1;
    assign exp_bit   = EXP_Q[step];
    assign step_good = (Q_I == exp_bit) && (Qn_I == ~exp_bit);

`ifdef DFF_BIST_STOP_EN
    assign end_run = (step == 3'd7) || !step_good;
`else
    assign end_run = (step == 3'd7);
`endif

    assign dbg_state = state;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state     <= S_IDLE;
            step      <= 3'd0;
            cnt       <= 4'd0;
            fail_seen <= 1'b0;
            D_O       <= 1'b0;
            PRE_O     <= 1'b1;
            CLR_O     <= 1'b1;
            CLK_O     <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            FAIL_STEP <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state                 <= S_APPLY;
                        step                  <= 3'd0;
                        fail_seen             <= 1'b0;
                        BUSY                  <= 1'b1;
                        DONE                  <= 1'b0;
                        PASS                  <= 1'b0;
                        FAIL_STEP             <= 3'd0;
                        // Step 0 vector is applied on the edge that enters APPLY.
                        {PRE_O, CLR_O, D_O}   <= rom_pins(3'd0);
                    end
                end

                S_APPLY: begin
                    state <= S_SETTLE;
                    cnt   <= SETTLE_LOAD;
                end

                S_SETTLE: begin
                    if (cnt == 4'd0) begin
                        if (CLOCKED[step]) begin
                            state <= S_CLK_HI;
                            CLK_O <= 1'b1;
                        end else begin
                            state <= S_CHECK;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                S_CLK_HI: begin
                    state <= S_CLK_LO;
                    CLK_O <= 1'b0;
                    cnt   <= SETTLE_LOAD;
                end

                S_CLK_LO: begin
                    if (cnt == 4'd0) begin
                        state <= S_CHECK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                S_CHECK: begin
                    // Only the first failure is recorded.
                    if (!step_good && !fail_seen) begin
                        fail_seen <= 1'b1;
                        FAIL_STEP <= step;
                    end
                    if (end_run) begin
                        state <= S_FIN;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        PASS  <= !fail_seen && step_good;
                    end else begin
                        state               <= S_APPLY;
                        step                <= step_inc;
                        {PRE_O, CLR_O, D_O} <= rom_pins(step_inc);
                    end
                end

                S_FIN: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
